// File: rtl/usart_tx_pkg.sv
// -----------------------------------------------------------------------------
// usart_tx_pkg
// Shared definitions for the USART transmitter slice:
//   - tx_state_e     : transmitter FSM states
//   - UPM_*          : parity-mode encodings of the i_upm input
//   - CHAR_LEN_MIN/MAX and clamp_len() : character-length limits and clamp
// -----------------------------------------------------------------------------
package usart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } tx_state_e;

    // 2'b01 is reserved and behaves exactly like UPM_NONE.
    localparam logic [1:0] UPM_NONE = 2'b00;
    localparam logic [1:0] UPM_EVEN = 2'b10;
    localparam logic [1:0] UPM_ODD  = 2'b11;

    localparam int unsigned CHAR_LEN_MIN = 5;
    localparam int unsigned CHAR_LEN_MAX = 9;

    // Clamp a requested character length into CHAR_LEN_MIN..max_len.
    function automatic logic [3:0] clamp_len(input logic [3:0] len,
                                             input logic [3:0] max_len);
        if (len < 4'(CHAR_LEN_MIN)) begin
            return 4'(CHAR_LEN_MIN);
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage : usart_tx_pkg

// File: rtl/usart_tx_fifo.sv
// -----------------------------------------------------------------------------
// usart_tx_fifo
// Transmit holding FIFO. Synchronous write and pop, head word always visible
// on o_rd_data. Full/empty flags are registered; a write while full is dropped
// and reported by a one-cycle o_wr_ovf pulse.
//   i_txclk   : clock
//   i_rst_n   : asynchronous active-low reset (empties the FIFO)
//   i_wr_en   : write strobe, accepted only when o_full is low
//   i_wr_data : word to store
//   i_rd_en   : pop strobe, honoured only when o_empty is low
//   o_rd_data : head word
//   o_full    : registered full flag
//   o_empty   : registered empty flag
//   o_wr_ovf  : one-cycle pulse after a dropped write
// -----------------------------------------------------------------------------
module usart_tx_fifo #(
    parameter int P_DATA_W     = 9,
    parameter int P_FIFO_DEPTH = 2
) (
    input  logic                i_txclk,
    input  logic                i_rst_n,
    input  logic                i_wr_en,
    input  logic [P_DATA_W-1:0] i_wr_data,
    input  logic                i_rd_en,
    output logic [P_DATA_W-1:0] o_rd_data,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_wr_ovf
);

    localparam int ADDR_W = $clog2(P_FIFO_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [P_DATA_W-1:0] mem_q [P_FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                full_q;
    logic                empty_q;
    logic                ovf_q;
    logic                wr_ok;
    logic                rd_ok;

    assign wr_ok = i_wr_en & ~full_q;
    assign rd_ok = i_rd_en & ~empty_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        count_d = count_q;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_txclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(P_FIFO_DEPTH));
            empty_q <= (count_d == '0);
            ovf_q   <= i_wr_en & full_q;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge i_txclk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= i_wr_data;
    end

    assign o_rd_data = mem_q[rd_ptr_q];
    assign o_full    = full_q;
    assign o_empty   = empty_q;
    assign o_wr_ovf  = ovf_q;

endmodule : usart_tx_fifo

// File: rtl/usart_tx_core.sv
// -----------------------------------------------------------------------------
// usart_tx_core
// Asynchronous-serial transmitter running at one bit time per clock. Frames
// are START, 5..P_DATA_W data bits LSB first, optional parity, one or two stop
// bits. Characters are queued in usart_tx_fifo; frames run back-to-back while
// the FIFO has data and the transmitter is enabled.
//   i_txclk    : bit-rate clock
//   i_rst_n    : asynchronous active-low reset
//   i_txen     : transmitter enable (sampled only at frame boundaries)
//   i_wr_en    : FIFO write strobe
//   i_wr_data  : character to send
//   i_char_len : data bits per frame (clamped to 5..P_DATA_W)
//   i_upm      : parity mode (00/01 none, 10 even, 11 odd)
//   i_usbs     : 0 = one stop bit, 1 = two stop bits
//   o_txd      : registered serial output, idle high
//   o_full     : FIFO full
//   o_empty    : FIFO empty
//   o_busy     : FSM not in IDLE
//   o_txc      : one-cycle transmit-complete pulse
//   o_wr_ovf   : one-cycle pulse after a dropped write
// -----------------------------------------------------------------------------
module usart_tx_core
    import usart_tx_pkg::*;
#(
    parameter int P_DATA_W     = 9,
    parameter int P_FIFO_DEPTH = 2
) (
    input  logic                i_txclk,
    input  logic                i_rst_n,
    input  logic                i_txen,
    input  logic                i_wr_en,
    input  logic [P_DATA_W-1:0] i_wr_data,
    input  logic [3:0]          i_char_len,
    input  logic [1:0]          i_upm,
    input  logic                i_usbs,
    output logic                o_txd,
    output logic                o_full,
    output logic                o_empty,
    output logic                o_busy,
    output logic                o_txc,
    output logic                o_wr_ovf
);

    tx_state_e           state_q, state_d;
    logic [P_DATA_W-1:0] shift_q, shift_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic                par_q, par_d;
    logic [1:0]          upm_q, upm_d;
    logic                usbs_q, usbs_d;
    logic                txd_q, txd_d;
    logic                txc_q, txc_d;

    logic                fifo_pop;
    logic                fifo_empty;
    logic [P_DATA_W-1:0] fifo_head;
    logic                frame_done;
    logic                start_frame;

    usart_tx_fifo #(
        .P_DATA_W     (P_DATA_W),
        .P_FIFO_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .i_txclk   (i_txclk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_data (i_wr_data),
        .i_rd_en   (fifo_pop),
        .o_rd_data (fifo_head),
        .o_full    (o_full),
        .o_empty   (fifo_empty),
        .o_wr_ovf  (o_wr_ovf)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        par_d       = par_q;
        upm_d       = upm_q;
        usbs_d      = usbs_q;
        txc_d       = 1'b0;
        txd_d       = 1'b1;
        fifo_pop    = 1'b0;
        frame_done  = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            IDLE:   start_frame = i_txen & ~fifo_empty;
            START:  state_d = DATA;
            DATA: begin
                // shift_q[0] is the bit on the line this cycle.
                par_d   = par_q ^ shift_q[0];
                shift_d = shift_q >> 1;
                if (bit_cnt_q == 4'd0) begin
                    state_d = (upm_q == UPM_EVEN || upm_q == UPM_ODD) ? PARITY : STOP1;
                end else begin
                    bit_cnt_d = bit_cnt_q - 4'd1;
                end
            end
            PARITY: state_d = STOP1;
            STOP1: begin
                if (usbs_q) state_d = STOP2;
                else        frame_done = 1'b1;
            end
            STOP2:  frame_done = 1'b1;
            default: state_d = IDLE;
        endcase

        if (frame_done) begin
            if (i_txen && !fifo_empty) begin
                start_frame = 1'b1;
            end else begin
                state_d = IDLE;
                txc_d   = 1'b1;
            end
        end

        // Popping latches the whole frame configuration; the bit counter
        // holds the effective length (minus one) for the rest of the frame.
        if (start_frame) begin
            fifo_pop  = 1'b1;
            state_d   = START;
            shift_d   = fifo_head;
            bit_cnt_d = clamp_len(i_char_len, 4'(P_DATA_W)) - 4'd1;
            par_d     = 1'b0;
            upm_d     = i_upm;
            usbs_d    = i_usbs;
        end

        // o_txd is registered, so it is driven from the state being entered.
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = (upm_q == UPM_ODD) ? ~par_d : par_d;
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_txclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            upm_q     <= UPM_NONE;
            usbs_q    <= 1'b0;
            txd_q     <= 1'b1;
            txc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            upm_q     <= upm_d;
            usbs_q    <= usbs_d;
            txd_q     <= txd_d;
            txc_q     <= txc_d;
        end
    end

    assign o_txd   = txd_q;
    assign o_empty = fifo_empty;
    assign o_busy  = (state_q != IDLE);
    assign o_txc   = txc_q;

endmodule : usart_tx_core

// File: tb/tb_usart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_usart_tx_core
// Scoreboard bench: each accepted write pushes the expected serial frame
// (built from the character and the line settings) into a queue; a monitor on
// the falling clock edge detects start bits, pops the expected frame and
// compares every bit, plus o_busy and o_txc on every cycle.
// -----------------------------------------------------------------------------
module tb_usart_tx_core;

    localparam int P_DATA_W     = 9;
    localparam int P_FIFO_DEPTH = 2;

    logic                i_txclk = 1'b0;
    logic                i_rst_n = 1'b0;
    logic                i_txen;
    logic                i_wr_en;
    logic [P_DATA_W-1:0] i_wr_data;
    logic [3:0]          i_char_len;
    logic [1:0]          i_upm;
    logic                i_usbs;
    logic                o_txd;
    logic                o_full;
    logic                o_empty;
    logic                o_busy;
    logic                o_txc;
    logic                o_wr_ovf;

    usart_tx_core #(
        .P_DATA_W     (P_DATA_W),
        .P_FIFO_DEPTH (P_FIFO_DEPTH)
    ) dut (
        .i_txclk    (i_txclk),
        .i_rst_n    (i_rst_n),
        .i_txen     (i_txen),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .i_char_len (i_char_len),
        .i_upm      (i_upm),
        .i_usbs     (i_usbs),
        .o_txd      (o_txd),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_busy     (o_busy),
        .o_txc      (o_txc),
        .o_wr_ovf   (o_wr_ovf)
    );

    always #5 i_txclk = ~i_txclk;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    frame_t exp_q[$];
    int     total = 0;
    int     bad   = 0;
    int     txc_cnt = 0;
    bit     in_frame = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: start bit, clamped number of data bits LSB first,
    // optional parity over exactly those bits, then the stop bits.
    function automatic frame_t make_frame(input logic [8:0] d, input logic [3:0] cl,
                                          input logic [1:0] upm, input logic usbs);
        frame_t f;
        int len;
        int ones;
        len = int'(cl);
        if (len < 5) len = 5;
        if (len > P_DATA_W) len = P_DATA_W;
        f.bits = '0;
        f.n = 0;
        f.bits[f.n] = 1'b0;
        f.n++;
        ones = 0;
        for (int i = 0; i < len; i++) begin
            f.bits[f.n] = d[i];
            if (d[i]) ones++;
            f.n++;
        end
        if (upm == 2'b10) begin
            f.bits[f.n] = (ones % 2 == 1);
            f.n++;
        end else if (upm == 2'b11) begin
            f.bits[f.n] = (ones % 2 == 0);
            f.n++;
        end
        repeat (usbs ? 2 : 1) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    // Monitor
    frame_t cur;
    int     idx = 0;
    bit     last_bit = 1'b0;

    always @(negedge i_txclk) begin
        bit part;
        bit exp_txc;
        if (!i_rst_n) begin
            in_frame = 1'b0;
            last_bit = 1'b0;
        end else begin
            exp_txc = last_bit && (o_txd === 1'b1);
            check("txc", 32'(o_txc), 32'(exp_txc));
            if (o_txc === 1'b1) txc_cnt++;
            last_bit = 1'b0;
            part = 1'b0;
            if (in_frame) begin
                part = 1'b1;
                check($sformatf("txd_bit%0d", idx), 32'(o_txd), 32'(cur.bits[idx]));
                idx++;
                if (idx == cur.n) begin
                    in_frame = 1'b0;
                    last_bit = 1'b1;
                end
            end else if (o_txd === 1'b0) begin
                part = 1'b1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got=start bit want=idle line at %0t", $time);
                end else begin
                    cur = exp_q.pop_front();
                    idx = 1;
                    in_frame = 1'b1;
                end
            end
            check("busy", 32'(o_busy), 32'(part));
        end
    end

    // Stimulus helpers: called and returning at posedge+1.
    task automatic wr(input logic [8:0] d, input bit push);
        i_wr_en   = 1'b1;
        i_wr_data = d;
        if (push) exp_q.push_back(make_frame(d, i_char_len, i_upm, i_usbs));
        @(posedge i_txclk);
        #1;
        i_wr_en = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] cl, input logic [1:0] upm, input logic usbs);
        i_char_len = cl;
        i_upm      = upm;
        i_usbs     = usbs;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge i_txclk);
            #1;
            if (exp_q.size() == 0 && !in_frame && o_busy === 1'b0) done = 1'b1;
        end
        check(name, 32'(done), 1);
        if (!done) exp_q.delete();
        @(posedge i_txclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        i_txen    = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_data = '0;
        cfg(4'd8, 2'b00, 1'b0);

        // Reset values
        repeat (3) @(posedge i_txclk);
        #1;
        check("rst_txd",   32'(o_txd),    1);
        check("rst_empty", 32'(o_empty),  1);
        check("rst_full",  32'(o_full),   0);
        check("rst_busy",  32'(o_busy),   0);
        check("rst_txc",   32'(o_txc),    0);
        check("rst_ovf",   32'(o_wr_ovf), 0);
        i_rst_n = 1'b1;
        @(posedge i_txclk);
        #1;

        // 8N1, 0xA5, start bit one edge after the write edge
        i_txen = 1'b1;
        t0 = txc_cnt;
        wr(9'h0A5, 1'b1);
        @(posedge i_txclk);
        #1;
        check("latency_start", 32'(o_txd), 0);
        wait_drain("drain_8n1");
        check("txc_once_8n1", 32'(txc_cnt - t0), 1);
        check("busy_after_8n1", 32'(o_busy), 0);

        // 7E2, 0x03
        cfg(4'd7, 2'b10, 1'b1);
        wr(9'h003, 1'b1);
        wait_drain("drain_7e2");

        // 9O1, 0x1FF, then char_len 12 clamps to 9
        cfg(4'd9, 2'b11, 1'b0);
        wr(9'h1FF, 1'b1);
        wait_drain("drain_9o1");
        cfg(4'd12, 2'b11, 1'b0);
        wr(9'h1FF, 1'b1);
        wait_drain("drain_9o1_clamp");

        // Overflow with transmitter disabled, then back-to-back release
        i_txen = 1'b0;
        cfg(4'd8, 2'b00, 1'b0);
        wr(9'h011, 1'b1);
        wr(9'h022, 1'b1);
        check("full_after_2", 32'(o_full), 1);
        check("empty_after_2", 32'(o_empty), 0);
        wr(9'h033, 1'b0);
        check("ovf_pulse", 32'(o_wr_ovf), 1);
        @(posedge i_txclk);
        #1;
        check("ovf_clear", 32'(o_wr_ovf), 0);
        check("full_kept", 32'(o_full), 1);
        t0 = txc_cnt;
        i_txen = 1'b1;
        wait_drain("drain_b2b");
        check("txc_once_b2b", 32'(txc_cnt - t0), 1);

        // Disable mid-frame: current frame finishes, queued word stays
        wr(9'h05A, 1'b1);
        wr(9'h0C3, 1'b1);
        repeat (3) @(posedge i_txclk);
        #1;
        i_txen = 1'b0;
        repeat (20) @(posedge i_txclk);
        #1;
        check("hold_pending", 32'(exp_q.size()), 1);
        check("hold_empty", 32'(o_empty), 0);
        check("hold_busy", 32'(o_busy), 0);
        i_txen = 1'b1;
        wait_drain("drain_resume");

        // Parity mode change during DATA only affects the next frame
        cfg(4'd8, 2'b00, 1'b0);
        wr(9'h0B7, 1'b1);
        repeat (3) @(posedge i_txclk);
        #1;
        i_upm = 2'b11;
        wr(9'h0B7, 1'b1);
        wait_drain("drain_upm_change");

        // Asynchronous reset during the 4th data bit
        cfg(4'd8, 2'b00, 1'b0);
        wr(9'h000, 1'b1);
        wr(9'h000, 1'b1);
        repeat (4) @(posedge i_txclk);
        #1;
        check("pre_rst_txd", 32'(o_txd), 0);
        check("pre_rst_empty", 32'(o_empty), 0);
        #1;
        i_rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_txd", 32'(o_txd), 1);
        check("async_rst_empty", 32'(o_empty), 1);
        check("async_rst_busy", 32'(o_busy), 0);
        repeat (2) @(posedge i_txclk);
        #1;
        i_rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge i_txclk);
            #1;
            check("post_rst_txd", 32'(o_txd), 1);
            check("post_rst_busy", 32'(o_busy), 0);
        end

        // Randomized frames and settings
        for (int it = 0; it < 25; it++) begin
            int n;
            cfg(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) wr(9'($urandom), 1'b1);
            wait_drain($sformatf("drain_rand%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_usart_tx_core
